// File: rtl/spi_flash_target_if.sv
`timescale 1ns/1ps
// SPI pin and read-memory port bundle for the flash responder.
// "master" is the initiator/memory side, "slave" is the responder.
interface spi_flash_target_if;
    logic        spi_sck;
    logic        spi_cs;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [23:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_data;

    modport master (
        output spi_sck,
        output spi_cs,
        output spi_mosi,
        output mem_rd_data,
        input  spi_miso,
        input  spi_miso_oe,
        input  mem_addr,
        input  mem_rd_en
    );

    modport slave (
        input  spi_sck,
        input  spi_cs,
        input  spi_mosi,
        input  mem_rd_data,
        output spi_miso,
        output spi_miso_oe,
        output mem_addr,
        output mem_rd_en
    );
endinterface

// File: rtl/spi_flash_target.sv
`timescale 1ns/1ps
// spi_flash_target: SPI mode-0 flash responder running in the 48 MHz domain.
// Oversamples SCK/CS/MOSI, answers JEDEC ID, status, read, power-down and
// release, and serves read data from a 1-cycle-latency memory port with a
// one-byte prefetch so the next byte is ready before its first SCK fall.
module spi_flash_target #(
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic              clk_48mhz,
    input  logic              reset,
    spi_flash_target_if.slave bus,
    input  logic [7:0]        status_in,
    output logic              powered_down
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CMD    = 3'd1;
    localparam logic [2:0] ADDR   = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;
    localparam logic [2:0] IGNORE = 3'd5;

    localparam logic [7:0] OP_JEDEC_ID   = 8'h9F;
    localparam logic [7:0] OP_STATUS     = 8'h05;
    localparam logic [7:0] OP_READ       = 8'h03;
    localparam logic [7:0] OP_POWER_DOWN = 8'hB9;
    localparam logic [7:0] OP_RELEASE    = 8'hAB;

    logic        sck_meta_q, sck_meta_d;
    logic        sck_sync_q, sck_sync_d;
    logic        sck_prev_q, sck_prev_d;
    logic        cs_meta_q, cs_meta_d;
    logic        cs_sync_q, cs_sync_d;
    logic        cs_prev_q, cs_prev_d;
    logic        mosi_meta_q, mosi_meta_d;
    logic        mosi_sync_q, mosi_sync_d;
    logic [1:0]  settle_q, settle_d;

    logic [2:0]  state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [22:0] shift_in_q, shift_in_d;
    logic [7:0]  shift_out_q, shift_out_d;
    logic [1:0]  resp_idx_q, resp_idx_d;
    logic        resp_status_q, resp_status_d;
    logic [23:0] mem_addr_q, mem_addr_d;
    logic        mem_rd_en_q, mem_rd_en_d;
    logic        capture_q, capture_d;
    logic [7:0]  prefetch_q, prefetch_d;
    logic        powered_down_q, powered_down_d;
    logic        pd_pend_q, pd_pend_d;
    logic        pd_val_q, pd_val_d;

    logic        sck_rise;
    logic        sck_fall;
    logic        cs_rise;
    logic        cs_fall;
    logic [7:0]  cmd_byte;
    logic [23:0] addr_word;
    logic [7:0]  jedec_byte;

    // Edge detection; cs_fall is held off until the synchroniser has
    // flushed its reset levels so a reset with CS held low cannot
    // restart a transaction without a real CS falling edge.
    assign sck_rise  = sck_sync_q & ~sck_prev_q;
    assign sck_fall  = ~sck_sync_q & sck_prev_q;
    assign cs_rise   = cs_sync_q & ~cs_prev_q;
    assign cs_fall   = ~cs_sync_q & cs_prev_q & (settle_q == 2'd3);

    assign cmd_byte  = {shift_in_q[6:0], mosi_sync_q};
    assign addr_word = {shift_in_q[22:0], mosi_sync_q};

    assign bus.spi_miso    = shift_out_q[7];
    assign bus.spi_miso_oe = ((state_q == RESP) || (state_q == DATA)) && !cs_sync_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_rd_en   = mem_rd_en_q;
    assign powered_down    = powered_down_q;

    // Selects the JEDEC ID byte for the current response position; zero once exhausted.
    always_comb begin
        jedec_byte = 8'h00;
        case (resp_idx_q)
            2'd0:    jedec_byte = JEDEC_ID[23:16];
            2'd1:    jedec_byte = JEDEC_ID[15:8];
            2'd2:    jedec_byte = JEDEC_ID[7:0];
            default: jedec_byte = 8'h00;
        endcase
    end

    // Next values for the two-stage synchronisers, the edge register and the settle counter.
    always_comb begin
        sck_meta_d  = bus.spi_sck;
        sck_sync_d  = sck_meta_q;
        sck_prev_d  = sck_sync_q;
        cs_meta_d   = bus.spi_cs;
        cs_sync_d   = cs_meta_q;
        cs_prev_d   = cs_sync_q;
        mosi_meta_d = bus.spi_mosi;
        mosi_sync_d = mosi_meta_q;
        settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    end

    // Protocol engine: CS release overrides everything, otherwise the
    // current state reacts to the synchronised SCK edges.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_in_d     = shift_in_q;
        shift_out_d    = shift_out_q;
        resp_idx_d     = resp_idx_q;
        resp_status_d  = resp_status_q;
        mem_addr_d     = mem_addr_q;
        mem_rd_en_d    = 1'b0;
        capture_d      = mem_rd_en_q;
        prefetch_d     = capture_q ? bus.mem_rd_data : prefetch_q;
        powered_down_d = powered_down_q;
        pd_pend_d      = pd_pend_q;
        pd_val_d       = pd_val_q;

        if (cs_rise) begin
            state_d     = IDLE;
            bit_cnt_d   = 5'd0;
            shift_in_d  = 23'd0;
            shift_out_d = 8'd0;
            resp_idx_d  = 2'd0;
            if (pd_pend_q) begin
                powered_down_d = pd_val_q;
                pd_pend_d      = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d    = CMD;
                        bit_cnt_d  = 5'd0;
                        shift_in_d = 23'd0;
                    end
                end

                CMD: begin
                    if (sck_rise) begin
                        shift_in_d = {shift_in_q[21:0], mosi_sync_q};
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            if (powered_down_q && (cmd_byte != OP_RELEASE)) begin
                                state_d = IGNORE;
                            end else begin
                                case (cmd_byte)
                                    OP_JEDEC_ID: begin
                                        state_d       = RESP;
                                        resp_status_d = 1'b0;
                                        resp_idx_d    = 2'd0;
                                    end
                                    OP_STATUS: begin
                                        state_d       = RESP;
                                        resp_status_d = 1'b1;
                                    end
                                    OP_READ: begin
                                        state_d = ADDR;
                                    end
                                    OP_POWER_DOWN: begin
                                        state_d   = IGNORE;
                                        pd_pend_d = 1'b1;
                                        pd_val_d  = 1'b1;
                                    end
                                    OP_RELEASE: begin
                                        state_d   = IGNORE;
                                        pd_pend_d = 1'b1;
                                        pd_val_d  = 1'b0;
                                    end
                                    default: begin
                                        state_d = IGNORE;
                                    end
                                endcase
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end

                ADDR: begin
                    if (sck_rise) begin
                        shift_in_d = {shift_in_q[21:0], mosi_sync_q};
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d   = 5'd0;
                            mem_addr_d  = addr_word;
                            mem_rd_en_d = 1'b1;
                            state_d     = DATA;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end

                DATA: begin
                    if (sck_rise) begin
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d   = 5'd0;
                            mem_addr_d  = mem_addr_q + 24'd1;
                            mem_rd_en_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                    if (sck_fall) begin
                        if (bit_cnt_q == 5'd0) begin
                            shift_out_d = prefetch_q;
                        end else begin
                            shift_out_d = {shift_out_q[6:0], 1'b0};
                        end
                    end
                end

                RESP: begin
                    if (sck_rise) begin
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                    if (sck_fall) begin
                        if (bit_cnt_q == 5'd0) begin
                            if (resp_status_q) begin
                                shift_out_d = status_in;
                            end else begin
                                shift_out_d = jedec_byte;
                                if (resp_idx_q != 2'd3) begin
                                    resp_idx_d = resp_idx_q + 2'd1;
                                end
                            end
                        end else begin
                            shift_out_d = {shift_out_q[6:0], 1'b0};
                        end
                    end
                end

                IGNORE: begin
                    state_d = IGNORE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Synchroniser registers; reset loads the idle pin levels (SCK low, CS high).
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            settle_q    <= 2'd0;
        end else begin
            sck_meta_q  <= sck_meta_d;
            sck_sync_q  <= sck_sync_d;
            sck_prev_q  <= sck_prev_d;
            cs_meta_q   <= cs_meta_d;
            cs_sync_q   <= cs_sync_d;
            cs_prev_q   <= cs_prev_d;
            mosi_meta_q <= mosi_meta_d;
            mosi_sync_q <= mosi_sync_d;
            settle_q    <= settle_d;
        end
    end

    // Protocol state, shift registers, memory port and power-down flag.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q        <= IDLE;
            bit_cnt_q      <= 5'd0;
            shift_in_q     <= 23'd0;
            shift_out_q    <= 8'd0;
            resp_idx_q     <= 2'd0;
            resp_status_q  <= 1'b0;
            mem_addr_q     <= 24'd0;
            mem_rd_en_q    <= 1'b0;
            capture_q      <= 1'b0;
            prefetch_q     <= 8'd0;
            powered_down_q <= 1'b0;
            pd_pend_q      <= 1'b0;
            pd_val_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_in_q     <= shift_in_d;
            shift_out_q    <= shift_out_d;
            resp_idx_q     <= resp_idx_d;
            resp_status_q  <= resp_status_d;
            mem_addr_q     <= mem_addr_d;
            mem_rd_en_q    <= mem_rd_en_d;
            capture_q      <= capture_d;
            prefetch_q     <= prefetch_d;
            powered_down_q <= powered_down_d;
            pd_pend_q      <= pd_pend_d;
            pd_val_q       <= pd_val_d;
        end
    end

endmodule
